vx_wb_dispatch: RTL and testbench
=================================

VX_WB_DISPATCH -- requirements
Module: VX_wb_dispatch

Interface
REQ-001 SHALL have parameter VFIFO_DEPTH, default 4, power of two >=2: vector-beat buffer entries.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wb_if  VX_writeback_if.slave  struct  writeback beat (valid, uuid, wis, tmask, PC, rd, data, sop, eop, is_vec, vd, lane_id); no backpressure exists.
REQ-005 SHALL have ports gpr_wr_valid/wis/rd/tmask/data  output  1/ISSUE_WIS_W/NR_BITS/NUM_THREADS/NUM_THREADS*XLEN  scalar register-file write.
REQ-006 SHALL have ports vrf_wr_valid/wis/vd/lane_id/tmask/data  output  1/ISSUE_WIS_W/NR_BITS/NR_BITS/NUM_THREADS/NUM_THREADS*XLEN  vector register-file write.
REQ-007 SHALL have port vrf_wr_ready  input  1  VRF accepts beat when valid&&ready.
REQ-008 SHALL have ports sb_rel_s_valid/wis/rd and sb_rel_v_valid/wis/vd  output  1/ISSUE_WIS_W/NR_BITS  scoreboard release, scalar and vector.
REQ-009 SHALL have ports ovf_err, proto_err  output  1  sticky error flags.

Function
REQ-010 SHALL route beats with is_vec=0 to the GPR port, registered: valid beat at cycle N appears on gpr_wr_* at N+1 for one cycle.
REQ-011 SHALL assert sb_rel_s_valid together with gpr_wr_valid when that scalar beat had eop=1, carrying its wis, rd.
REQ-012 SHALL push beats with is_vec=1 into a VFIFO_DEPTH FIFO; vrf_wr_* presents head entry with vrf_wr_valid = !empty, first-word-fall-through, minimum latency 1 cycle (push N, visible N+1).
REQ-013 SHALL pop head when vrf_wr_valid && vrf_wr_ready; vrf_wr_* stable while valid && !ready.
REQ-014 SHALL assert sb_rel_v_valid for one cycle in the cycle following the pop of a beat whose eop=1, carrying its wis, vd.
REQ-015 SHALL, on push when full and no pop that cycle, drop the beat and set ovf_err; push when full with simultaneous pop SHALL be accepted.
REQ-016 SHALL track vector stream state FSM: IDLE -> BURST on vec sop&&!eop; BURST -> IDLE on vec eop; vec sop&&eop in IDLE stays IDLE.
REQ-017 SHALL set proto_err on vec beat with sop=1 in BURST, or sop=0 in IDLE; beat still pushed, FSM takes sop/eop at face value.
REQ-018 SHALL allow scalar and vector beats to be handled independently; scalar and vector releases in the same cycle both asserted.
REQ-019 SHALL ignore wb_if.data fields when valid=0.

Reset
REQ-020 SHALL on reset: FIFO empty, pointers/count 0, FSM IDLE, all *_valid 0, ovf_err/proto_err 0, perf counters 0; data outputs don't-care.
REQ-021 SHALL discard in-flight FIFO beats and pending releases on reset mid-burst; beats presented during reset ignored.
REQ-022 SHALL clear sticky errors only by reset.

Configuration
REQ-023 SHALL, with VX_WB_DISPATCH_PERF_EN defined, provide 32-bit wrapping outputs perf_gpr_writes, perf_vrf_writes, perf_vrf_stalls (cycles valid&&!ready); without it those ports and counters SHALL not exist and function is otherwise identical.

Structure
REQ-024 SHALL place release struct typedef (wis, reg, valid) and VFIFO_DEPTH default in VX_gpu_pkg.
REQ-025 SHALL implement vector buffer as sub-module VX_wb_vfifo (push/pop/full/empty/count).
REQ-026 SHALL contain no combinational path from wb_if to any output.

Verification
REQ-027 SHALL cover: scalar beat rd=5, wis=2, eop=1 at N -> gpr_wr_valid and sb_rel_s_valid rd=5 at N+1 only.
REQ-028 SHALL cover: vec burst 4 beats (sop on 1st, eop on 4th), vd=8, ready=1 -> 4 vrf writes lane_id in order, sb_rel_v_valid once, cycle after 4th pop.
REQ-029 SHALL cover: ready=0, 5 vec beats with depth 4 -> 4 held, 5th dropped, ovf_err=1; ready=1 then 4 pops in order.
REQ-030 SHALL cover: full FIFO with ready=1 and new push same cycle -> accepted, count stays 4, ovf_err stays 0.
REQ-031 SHALL cover: vec beat sop=0 in IDLE -> proto_err=1, beat still written; reset mid-burst -> FIFO empty, no release, flags 0.
REQ-032 SHALL cover: scalar eop and vector eop pop in the same cycle -> both release valids asserted together.

Source files
------------

// File: rtl/vx_wb_dispatch_pkg.sv
// Shared types and sizing for the writeback dispatcher: release record,
// vector-beat buffer entry, vector stream FSM states and default depths.
package vx_wb_dispatch_pkg;

  localparam int NUM_THREADS     = 4;
  localparam int XLEN            = 32;
  localparam int NR_BITS         = 6;
  localparam int ISSUE_WIS_W     = 2;
  localparam int UUID_W          = 8;
  localparam int PC_W            = 32;
  localparam int VFIFO_DEPTH_DEF = 4;

  // Scoreboard release record (reg is the scalar rd or the vector vd).
  typedef struct packed {
    logic                   valid;
    logic [ISSUE_WIS_W-1:0] wis;
    logic [NR_BITS-1:0]     rd;
  } sb_rel_t;

  // One buffered vector beat; only what the VRF write and release need.
  typedef struct packed {
    logic [ISSUE_WIS_W-1:0]      wis;
    logic [NR_BITS-1:0]          vd;
    logic [NR_BITS-1:0]          lane_id;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } vbeat_t;

  localparam int VBEAT_W = $bits(vbeat_t);

  typedef enum logic {
    VS_IDLE  = 1'b0,
    VS_BURST = 1'b1
  } vstate_e;

endpackage

// File: rtl/vx_wb_dispatch_if.sv
// Writeback beat bus feeding the dispatcher. There is no backpressure:
// the producer drives a beat whenever valid is high.
interface vx_wb_dispatch_if;
  import vx_wb_dispatch_pkg::*;

  logic                        valid;
  logic [UUID_W-1:0]           uuid;
  logic [ISSUE_WIS_W-1:0]      wis;
  logic [NUM_THREADS-1:0]      tmask;
  logic [PC_W-1:0]             pc;
  logic [NR_BITS-1:0]          rd;
  logic [NUM_THREADS*XLEN-1:0] data;
  logic                        sop;
  logic                        eop;
  logic                        is_vec;
  logic [NR_BITS-1:0]          vd;
  logic [NR_BITS-1:0]          lane_id;

  modport master (
    output valid, uuid, wis, tmask, pc, rd, data, sop, eop, is_vec, vd, lane_id
  );

  modport slave (
    input valid, uuid, wis, tmask, pc, rd, data, sop, eop, is_vec, vd, lane_id
  );

endinterface

// File: rtl/vx_wb_dispatch_vfifo.sv
// Vector-beat buffer: DEPTH-entry first-word-fall-through FIFO. A push on
// a full FIFO is accepted only when a pop happens in the same cycle.
module vx_wb_dispatch_vfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Accept/pop qualification and next pointer/count values.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vx_wb_dispatch.sv
// Writeback dispatcher: scalar beats go to the GPR write port one cycle
// later; vector beats are buffered and drained to the VRF under
// vrf_wr_ready. Scoreboard releases fire on end-of-packet beats.
// Optional macro VX_WB_DISPATCH_PERF_EN adds 32-bit wrapping perf counters.
module vx_wb_dispatch
  import vx_wb_dispatch_pkg::*;
#(
  parameter int VFIFO_DEPTH = VFIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  vx_wb_dispatch_if.slave             wb_if,
  output logic                        gpr_wr_valid,
  output logic [ISSUE_WIS_W-1:0]      gpr_wr_wis,
  output logic [NR_BITS-1:0]          gpr_wr_rd,
  output logic [NUM_THREADS-1:0]      gpr_wr_tmask,
  output logic [NUM_THREADS*XLEN-1:0] gpr_wr_data,
  output logic                        vrf_wr_valid,
  output logic [ISSUE_WIS_W-1:0]      vrf_wr_wis,
  output logic [NR_BITS-1:0]          vrf_wr_vd,
  output logic [NR_BITS-1:0]          vrf_wr_lane_id,
  output logic [NUM_THREADS-1:0]      vrf_wr_tmask,
  output logic [NUM_THREADS*XLEN-1:0] vrf_wr_data,
  input  logic                        vrf_wr_ready,
  output logic                        sb_rel_s_valid,
  output logic [ISSUE_WIS_W-1:0]      sb_rel_s_wis,
  output logic [NR_BITS-1:0]          sb_rel_s_rd,
  output logic                        sb_rel_v_valid,
  output logic [ISSUE_WIS_W-1:0]      sb_rel_v_wis,
  output logic [NR_BITS-1:0]          sb_rel_v_vd,
  output logic                        ovf_err,
  output logic                        proto_err
`ifdef VX_WB_DISPATCH_PERF_EN
  ,
  output logic [31:0]                 perf_gpr_writes,
  output logic [31:0]                 perf_vrf_writes,
  output logic [31:0]                 perf_vrf_stalls
`endif
);

  logic                        scal_beat, vec_beat;
  logic                        vf_pop, vf_full, vf_empty;
  logic [$clog2(VFIFO_DEPTH):0] vf_count;
  logic [VBEAT_W-1:0]          vf_push_bits, vf_head_bits;
  vbeat_t                      vf_push, vf_head;

  logic                        gpr_vld_q, gpr_vld_d;
  logic [NUM_THREADS-1:0]      gpr_tmask_q, gpr_tmask_d;
  logic [NUM_THREADS*XLEN-1:0] gpr_data_q, gpr_data_d;
  sb_rel_t                     rel_s_q, rel_s_d;
  sb_rel_t                     rel_v_q, rel_v_d;
  vstate_e                     state_q, state_d;
  logic                        ovf_q, ovf_d;
  logic                        proto_q, proto_d;

  assign scal_beat = wb_if.valid && !wb_if.is_vec;
  assign vec_beat  = wb_if.valid &&  wb_if.is_vec;

  assign vf_push.wis     = wb_if.wis;
  assign vf_push.vd      = wb_if.vd;
  assign vf_push.lane_id = wb_if.lane_id;
  assign vf_push.tmask   = wb_if.tmask;
  assign vf_push.data    = wb_if.data;
  assign vf_push.eop     = wb_if.eop;
  assign vf_push_bits    = vf_push;
  assign vf_head         = vbeat_t'(vf_head_bits);
  assign vf_pop          = !vf_empty && vrf_wr_ready;

  vx_wb_dispatch_vfifo #(
    .DEPTH (VFIFO_DEPTH),
    .W     (VBEAT_W)
  ) u_vfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vec_beat),
    .push_data (vf_push_bits),
    .pop       (vf_pop),
    .head_data (vf_head_bits),
    .full      (vf_full),
    .empty     (vf_empty),
    .count     (vf_count)
  );

  // Next-state for the scalar path, releases, stream FSM and sticky errors.
  always_comb begin
    gpr_vld_d   = scal_beat;
    gpr_tmask_d = scal_beat ? wb_if.tmask : gpr_tmask_q;
    gpr_data_d  = scal_beat ? wb_if.data  : gpr_data_q;
    rel_s_d.valid = scal_beat && wb_if.eop;
    rel_s_d.wis   = scal_beat ? wb_if.wis : rel_s_q.wis;
    rel_s_d.rd    = scal_beat ? wb_if.rd  : rel_s_q.rd;

    rel_v_d.valid = vf_pop && vf_head.eop;
    rel_v_d.wis   = vf_pop ? vf_head.wis : rel_v_q.wis;
    rel_v_d.rd    = vf_pop ? vf_head.vd  : rel_v_q.rd;

    state_d = state_q;
    proto_d = proto_q;
    if (vec_beat) begin
      if ((wb_if.sop && state_q == VS_BURST) || (!wb_if.sop && state_q == VS_IDLE))
        proto_d = 1'b1;
      if (wb_if.eop)      state_d = VS_IDLE;
      else if (wb_if.sop) state_d = VS_BURST;
    end

    ovf_d = ovf_q || (vec_beat && vf_full && !vf_pop);
  end

  // Registered state; only valids, FSM and flags are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_vld_q     <= 1'b0;
      rel_s_q.valid <= 1'b0;
      rel_v_q.valid <= 1'b0;
      state_q       <= VS_IDLE;
      ovf_q         <= 1'b0;
      proto_q       <= 1'b0;
    end else begin
      gpr_vld_q   <= gpr_vld_d;
      gpr_tmask_q <= gpr_tmask_d;
      gpr_data_q  <= gpr_data_d;
      rel_s_q     <= rel_s_d;
      rel_v_q     <= rel_v_d;
      state_q     <= state_d;
      ovf_q       <= ovf_d;
      proto_q     <= proto_d;
    end
  end

  assign gpr_wr_valid   = gpr_vld_q;
  assign gpr_wr_wis     = rel_s_q.wis;
  assign gpr_wr_rd      = rel_s_q.rd;
  assign gpr_wr_tmask   = gpr_tmask_q;
  assign gpr_wr_data    = gpr_data_q;

  assign vrf_wr_valid   = !vf_empty;
  assign vrf_wr_wis     = vf_head.wis;
  assign vrf_wr_vd      = vf_head.vd;
  assign vrf_wr_lane_id = vf_head.lane_id;
  assign vrf_wr_tmask   = vf_head.tmask;
  assign vrf_wr_data    = vf_head.data;

  assign sb_rel_s_valid = rel_s_q.valid;
  assign sb_rel_s_wis   = rel_s_q.wis;
  assign sb_rel_s_rd    = rel_s_q.rd;
  assign sb_rel_v_valid = rel_v_q.valid;
  assign sb_rel_v_wis   = rel_v_q.wis;
  assign sb_rel_v_vd    = rel_v_q.rd;

  assign ovf_err   = ovf_q;
  assign proto_err = proto_q;

  // Buffer flags must agree with its occupancy.
  vf_count_consistent: assert property (@(posedge clk) disable iff (reset)
    vf_empty == (vf_count == '0));

`ifdef VX_WB_DISPATCH_PERF_EN
  logic [31:0] pg_q, pg_d, pv_q, pv_d, ps_q, ps_d;

  // Wrapping event counters.
  always_comb begin
    pg_d = pg_q + 32'(gpr_vld_q);
    pv_d = pv_q + 32'(vf_pop);
    ps_d = ps_q + 32'(!vf_empty && !vrf_wr_ready);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pg_q <= '0;
      pv_q <= '0;
      ps_q <= '0;
    end else begin
      pg_q <= pg_d;
      pv_q <= pv_d;
      ps_q <= ps_d;
    end
  end

  assign perf_gpr_writes = pg_q;
  assign perf_vrf_writes = pv_q;
  assign perf_vrf_stalls = ps_q;
`endif

endmodule

// File: tb/tb_vx_wb_dispatch.sv
// Directed bench for vx_wb_dispatch: scalar routing, vector bursts,
// overflow, full-with-pop, protocol errors, reset mid-burst and
// simultaneous releases. Honours VX_WB_DISPATCH_PERF_EN when defined.
module tb_vx_wb_dispatch;
  import vx_wb_dispatch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_wb_dispatch_if wb();

  logic                        gpr_wr_valid;
  logic [ISSUE_WIS_W-1:0]      gpr_wr_wis;
  logic [NR_BITS-1:0]          gpr_wr_rd;
  logic [NUM_THREADS-1:0]      gpr_wr_tmask;
  logic [NUM_THREADS*XLEN-1:0] gpr_wr_data;
  logic                        vrf_wr_valid;
  logic [ISSUE_WIS_W-1:0]      vrf_wr_wis;
  logic [NR_BITS-1:0]          vrf_wr_vd;
  logic [NR_BITS-1:0]          vrf_wr_lane_id;
  logic [NUM_THREADS-1:0]      vrf_wr_tmask;
  logic [NUM_THREADS*XLEN-1:0] vrf_wr_data;
  logic                        vrf_wr_ready;
  logic                        sb_rel_s_valid;
  logic [ISSUE_WIS_W-1:0]      sb_rel_s_wis;
  logic [NR_BITS-1:0]          sb_rel_s_rd;
  logic                        sb_rel_v_valid;
  logic [ISSUE_WIS_W-1:0]      sb_rel_v_wis;
  logic [NR_BITS-1:0]          sb_rel_v_vd;
  logic                        ovf_err;
  logic                        proto_err;
`ifdef VX_WB_DISPATCH_PERF_EN
  logic [31:0] perf_gpr_writes, perf_vrf_writes, perf_vrf_stalls;
`endif

  vx_wb_dispatch #(.VFIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_if          (wb),
    .gpr_wr_valid   (gpr_wr_valid),
    .gpr_wr_wis     (gpr_wr_wis),
    .gpr_wr_rd      (gpr_wr_rd),
    .gpr_wr_tmask   (gpr_wr_tmask),
    .gpr_wr_data    (gpr_wr_data),
    .vrf_wr_valid   (vrf_wr_valid),
    .vrf_wr_wis     (vrf_wr_wis),
    .vrf_wr_vd      (vrf_wr_vd),
    .vrf_wr_lane_id (vrf_wr_lane_id),
    .vrf_wr_tmask   (vrf_wr_tmask),
    .vrf_wr_data    (vrf_wr_data),
    .vrf_wr_ready   (vrf_wr_ready),
    .sb_rel_s_valid (sb_rel_s_valid),
    .sb_rel_s_wis   (sb_rel_s_wis),
    .sb_rel_s_rd    (sb_rel_s_rd),
    .sb_rel_v_valid (sb_rel_v_valid),
    .sb_rel_v_wis   (sb_rel_v_wis),
    .sb_rel_v_vd    (sb_rel_v_vd),
    .ovf_err        (ovf_err),
    .proto_err      (proto_err)
`ifdef VX_WB_DISPATCH_PERF_EN
    ,
    .perf_gpr_writes(perf_gpr_writes),
    .perf_vrf_writes(perf_vrf_writes),
    .perf_vrf_stalls(perf_vrf_stalls)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.valid   = 1'b0;
    wb.uuid    = '0;
    wb.wis     = '0;
    wb.tmask   = '0;
    wb.pc      = '0;
    wb.rd      = '0;
    wb.data    = '0;
    wb.sop     = 1'b0;
    wb.eop     = 1'b0;
    wb.is_vec  = 1'b0;
    wb.vd      = '0;
    wb.lane_id = '0;
  endtask

  task automatic scal(input int wis, input int rd, input bit eop, input int k);
    idle();
    wb.valid = 1'b1;
    wb.wis   = ISSUE_WIS_W'(wis);
    wb.rd    = NR_BITS'(rd);
    wb.eop   = eop;
    wb.sop   = 1'b1;
    wb.tmask = 4'hF;
    wb.data  = pat(k);
  endtask

  task automatic vec(input bit sop, input bit eop, input int lane, input int vd, input int wis);
    idle();
    wb.valid   = 1'b1;
    wb.is_vec  = 1'b1;
    wb.sop     = sop;
    wb.eop     = eop;
    wb.lane_id = NR_BITS'(lane);
    wb.vd      = NR_BITS'(vd);
    wb.wis     = ISSUE_WIS_W'(wis);
    wb.tmask   = 4'hA;
    wb.data    = pat(100 + lane);
  endtask

  initial begin
    idle();
    vrf_wr_ready = 1'b1;
    reset = 1'b1;
    step(); step(); step();
    check("rst_gpr_v", gpr_wr_valid, 0);
    check("rst_vrf_v", vrf_wr_valid, 0);
    check("rst_rel_s", sb_rel_s_valid, 0);
    check("rst_rel_v", sb_rel_v_valid, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_proto", proto_err, 0);
    reset = 1'b0;
    step();

    // Scalar beat with eop: one-cycle write and release.
    scal(2, 5, 1'b1, 7);
    step();
    idle();
    check("s_gpr_v", gpr_wr_valid, 1);
    check("s_gpr_rd", gpr_wr_rd, 5);
    check("s_gpr_wis", gpr_wr_wis, 2);
    check("s_gpr_tmask", gpr_wr_tmask, 4'hF);
    check("s_gpr_data", gpr_wr_data, pat(7));
    check("s_rel_v", sb_rel_s_valid, 1);
    check("s_rel_rd", sb_rel_s_rd, 5);
    check("s_rel_wis", sb_rel_s_wis, 2);
    check("s_no_vrf", vrf_wr_valid, 0);
    step();
    check("s_gpr_v_off", gpr_wr_valid, 0);
    check("s_rel_off", sb_rel_s_valid, 0);

    // Scalar beat without eop: write but no release.
    scal(1, 9, 1'b0, 3);
    step();
    idle();
    check("s2_gpr_v", gpr_wr_valid, 1);
    check("s2_gpr_rd", gpr_wr_rd, 9);
    check("s2_rel", sb_rel_s_valid, 0);
    step();

    // Four-beat vector burst drained at full rate.
    vrf_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec(k == 0, k == 3, k, 8, 1);
      step();
      check("b_vrf_v", vrf_wr_valid, 1);
      check("b_lane", vrf_wr_lane_id, k);
      check("b_vd", vrf_wr_vd, 8);
      check("b_data", vrf_wr_data, pat(100 + k));
      check("b_rel_early", sb_rel_v_valid, 0);
    end
    idle();
    step();
    check("b_empty", vrf_wr_valid, 0);
    check("b_rel_v", sb_rel_v_valid, 1);
    check("b_rel_vd", sb_rel_v_vd, 8);
    check("b_rel_wis", sb_rel_v_wis, 1);
    step();
    check("b_rel_once", sb_rel_v_valid, 0);
    check("b_proto", proto_err, 0);
    check("b_ovf", ovf_err, 0);

    // Overflow: five beats into a four-deep buffer with ready low.
    vrf_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec(k == 0, k == 4, k, 3, 2);
      step();
      check("o_ovf", ovf_err, (k == 4) ? 1 : 0);
    end
    idle();
    check("o_count", dut.u_vfifo.count_q, 4);
    check("o_head", vrf_wr_lane_id, 0);
    step();
    check("o_hold_lane", vrf_wr_lane_id, 0);
    check("o_hold_data", vrf_wr_data, pat(100));
    vrf_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("o_vrf_v", vrf_wr_valid, 1);
      check("o_lane", vrf_wr_lane_id, k);
      check("o_no_rel", sb_rel_v_valid, 0);
      step();
    end
    check("o_empty", vrf_wr_valid, 0);
    check("o_rel_dropped", sb_rel_v_valid, 0);
    check("o_ovf_sticky", ovf_err, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("o_ovf_clr", ovf_err, 0);

    // Full buffer with simultaneous pop and push.
    vrf_wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec(k == 0, 1'b0, k, 4, 3);
      step();
    end
    check("f_count_full", dut.u_vfifo.count_q, 4);
    vec(1'b0, 1'b1, 4, 4, 3);
    vrf_wr_ready = 1'b1;
    step();
    idle();
    check("f_count", dut.u_vfifo.count_q, 4);
    check("f_lane1", vrf_wr_lane_id, 1);
    check("f_ovf", ovf_err, 0);
    for (int k = 2; k < 5; k++) begin
      step();
      check("f_lane", vrf_wr_lane_id, k);
      check("f_no_rel", sb_rel_v_valid, 0);
    end
    step();
    check("f_empty", vrf_wr_valid, 0);
    check("f_rel_v", sb_rel_v_valid, 1);
    check("f_rel_vd", sb_rel_v_vd, 4);
    check("f_rel_wis", sb_rel_v_wis, 3);
    check("f_proto", proto_err, 0);

    // Vector beat without sop while idle.
    vec(1'b0, 1'b1, 5, 10, 0);
    step();
    idle();
    check("p_proto", proto_err, 1);
    check("p_vrf_v", vrf_wr_valid, 1);
    check("p_lane", vrf_wr_lane_id, 5);
    step();
    check("p_rel_v", sb_rel_v_valid, 1);
    check("p_rel_vd", sb_rel_v_vd, 10);
    check("p_empty", vrf_wr_valid, 0);

    // Reset in the middle of a burst.
    vrf_wr_ready = 1'b0;
    vec(1'b1, 1'b0, 0, 12, 1);
    step();
    vec(1'b0, 1'b0, 1, 12, 1);
    step();
    check("r_count", dut.u_vfifo.count_q, 2);
    reset = 1'b1;
    vec(1'b0, 1'b1, 2, 12, 1);
    step();
    idle();
    reset = 1'b0;
    check("r_vrf_v", vrf_wr_valid, 0);
    check("r_count0", dut.u_vfifo.count_q, 0);
    check("r_rel_v", sb_rel_v_valid, 0);
    check("r_ovf", ovf_err, 0);
    check("r_proto", proto_err, 0);
    vrf_wr_ready = 1'b1;
    step();
    check("r_rel_v2", sb_rel_v_valid, 0);
    check("r_vrf_v2", vrf_wr_valid, 0);
    vec(1'b1, 1'b1, 6, 12, 1);
    step();
    idle();
    check("r_fsm_idle", proto_err, 0);
    check("r_lane", vrf_wr_lane_id, 6);
    step();
    check("r_rel_single", sb_rel_v_valid, 1);
    step();

    // Scalar and vector releases land in the same cycle.
    vec(1'b1, 1'b1, 7, 13, 2);
    step();
    scal(3, 21, 1'b1, 21);
    step();
    idle();
    check("d_rel_s", sb_rel_s_valid, 1);
    check("d_rel_v", sb_rel_v_valid, 1);
    check("d_rel_s_rd", sb_rel_s_rd, 21);
    check("d_rel_v_vd", sb_rel_v_vd, 13);
    check("d_gpr_v", gpr_wr_valid, 1);
    step();
    check("d_rel_s_off", sb_rel_s_valid, 0);
    check("d_rel_v_off", sb_rel_v_valid, 0);

`ifdef VX_WB_DISPATCH_PERF_EN
    check("perf_gpr", perf_gpr_writes, 1);
    check("perf_vrf", perf_vrf_writes, 2);
    check("perf_stall", perf_vrf_stalls, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
